// File: rtl/mmp_control_unit.sv
// ============================================================================
// Module      : mmp_control_unit
// Description : Moore sequencer for the shift-add multiplier datapath (A, Q, M, P).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmp_control_unit #(
  parameter int ANCHO = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q0,
  input  logic             p_zero,
  output logic [3:0]       ctrl_a,
  output logic [3:0]       ctrl_q,
  output logic [3:0]       ctrl_m,
  output logic [3:0]       ctrl_p,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] ciclos
);

  localparam int SH_W = $clog2(ANCHO + 1);

  localparam logic [3:0] c_cmd_hold  = 4'b0000;
  localparam logic [3:0] c_cmd_add   = 4'b1000;
  localparam logic [3:0] c_cmd_shift = 4'b0100;
  localparam logic [3:0] c_cmd_decr  = 4'b0010;
  localparam logic [3:0] c_cmd_load  = 4'b0001;

  localparam logic [CNT_W-1:0] c_cic_max  = {CNT_W{1'b1}};
  localparam logic [SH_W-1:0]  c_sh_limit = SH_W'(ANCHO);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SH_W-1:0]  shcnt_q, shcnt_d, w_shcnt_inc;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ciclos_q, ciclos_d;
  logic [3:0]       ctrl_a_q, ctrl_a_d;
  logic [3:0]       ctrl_q_q, ctrl_q_d;
  logic [3:0]       ctrl_m_q, ctrl_m_d;
  logic [3:0]       ctrl_p_q, ctrl_p_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    shcnt_d     = shcnt_q;
    err_d       = err_q;
    ciclos_d    = ciclos_q;
    w_shcnt_inc = shcnt_q + SH_W'(1);

    if (((state_q == S_LOAD) || (state_q == S_ADD) || (state_q == S_SHIFT)) &&
        (ciclos_q != c_cic_max)) begin
      ciclos_d = ciclos_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          ciclos_d = '0;
          err_d    = 1'b0;
          shcnt_d  = '0;
        end
      end
      S_LOAD:  state_d = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        shcnt_d = w_shcnt_inc;
        if (p_zero) begin
          state_d = S_DONE;
        end else if (w_shcnt_inc == c_sh_limit) begin
          // P never reached zero within ANCHO shifts: abandon the product
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = q0 ? S_ADD : S_SHIFT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    ctrl_a_d = c_cmd_hold;
    ctrl_q_d = c_cmd_hold;
    ctrl_m_d = c_cmd_hold;
    ctrl_p_d = c_cmd_hold;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_LOAD: begin
        ctrl_a_d = c_cmd_load;
        ctrl_q_d = c_cmd_load;
        ctrl_m_d = c_cmd_load;
        ctrl_p_d = c_cmd_load;
        busy_d   = 1'b1;
      end
      S_ADD: begin
        ctrl_a_d = c_cmd_add;
        busy_d   = 1'b1;
      end
      S_SHIFT: begin
        ctrl_a_d = c_cmd_shift;
        ctrl_q_d = c_cmd_shift;
        ctrl_p_d = c_cmd_decr;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shcnt_q  <= '0;
      err_q    <= 1'b0;
      ciclos_q <= '0;
      ctrl_a_q <= c_cmd_hold;
      ctrl_q_q <= c_cmd_hold;
      ctrl_m_q <= c_cmd_hold;
      ctrl_p_q <= c_cmd_hold;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shcnt_q  <= shcnt_d;
      err_q    <= err_d;
      ciclos_q <= ciclos_d;
      ctrl_a_q <= ctrl_a_d;
      ctrl_q_q <= ctrl_q_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_p_q <= ctrl_p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ctrl_a = ctrl_a_q;
  assign ctrl_q = ctrl_q_q;
  assign ctrl_m = ctrl_m_q;
  assign ctrl_p = ctrl_p_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign ciclos = ciclos_q;

endmodule

`default_nettype wire
